// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem req/ack handshake and IF/ID register.
// Latency: with ack in the request cycle, the instruction reaches IF/ID on the next edge.
// Backpressure: PCWrite/IF_ID_Write stalls park a returned word in a one-entry hold buffer.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            PCWrite_i,
   input  logic            IF_ID_Write_i,
   input  logic            Branch_i,
   input  logic [XLEN-1:0] BranchTarget_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_data_i,
   output logic [XLEN-1:0] IF_ID_PC_o,
   output logic [XLEN-1:0] IF_ID_Instr_o,
   output logic            IF_ID_Valid_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_pc;   // branch target waiting for the in-flight request to finish
   logic [XLEN-1:0] hold_buf;      // word that returned while the pipeline was stalled

   logic            ack;
   logic            advance;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] pc_inc;
   logic            deliver;
   logic [XLEN-1:0] deliver_instr;

   // Low target bits are forced to zero, so they are never consumed.
   logic unused_tgt_bits;
   assign unused_tgt_bits = ^BranchTarget_i[1:0];

   assign ack         = imem_ack_i & imem_req_o;
   assign advance     = PCWrite_i & IF_ID_Write_i;
   assign br_target   = {BranchTarget_i[XLEN-1:2], 2'b00};
   assign pc_inc      = pc + XLEN'(4);
   // The PC is never changed while a request is open, so it doubles as the stable fetch address.
   assign imem_req_o  = (state == S_FETCH) || (state == S_DRAIN);
   assign imem_addr_o = pc;

   // Decide whether an instruction is handed to ID this cycle, and which word it is.
   always_comb begin
      deliver       = 1'b0;
      deliver_instr = imem_data_i;
      if (!Branch_i && advance) begin
         case (state)
            S_FETCH: deliver = ack;
            S_HOLD: begin
               deliver       = 1'b1;
               deliver_instr = hold_buf;
            end
            default: deliver = 1'b0;
         endcase
      end
   end

   // Fetch FSM: PC, redirect latch and hold buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         redirect_pc <= '0;
         hold_buf    <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (Branch_i) begin
                  if (ack) begin
                     pc <= br_target;
                  end else begin
                     // Address must stay put until the memory answers; redirect afterwards.
                     redirect_pc <= br_target;
                     state       <= S_DRAIN;
                  end
               end else if (ack) begin
                  if (advance) begin
                     pc <= pc_inc;
                  end else begin
                     hold_buf <= imem_data_i;
                     state    <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (Branch_i) begin
                  pc    <= br_target;
                  state <= S_FETCH;
               end else if (advance) begin
                  pc    <= pc_inc;
                  state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (ack) begin
                  // A branch arriving together with the ack is the newest redirect.
                  pc    <= Branch_i ? br_target : redirect_pc;
                  state <= S_FETCH;
               end else if (Branch_i) begin
                  redirect_pc <= br_target;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // IF/ID register: flush on branch, hold on stall, otherwise instruction or bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         IF_ID_PC_o    <= '0;
         IF_ID_Instr_o <= NOP;
         IF_ID_Valid_o <= 1'b0;
      end else if (Branch_i) begin
         IF_ID_PC_o    <= pc;
         IF_ID_Instr_o <= NOP;
         IF_ID_Valid_o <= 1'b0;
      end else if (IF_ID_Write_i) begin
         IF_ID_PC_o    <= pc;
         IF_ID_Instr_o <= deliver ? deliver_instr : NOP;
         IF_ID_Valid_o <= deliver;
      end
   end

endmodule
